// File: rtl/ahb_mem_sub_if.sv
// AHB-Lite subordinate-side signals plus the request/response channel to the memory controller.
// The slave modport is the front-end's view; master is the view of everything around it.
interface ahb_mem_sub_if #(
  parameter int DataWidth = 32,
  parameter int AddrWidth = 32
);
  logic                 hsel;
  logic [AddrWidth-1:0] haddr;
  logic [1:0]           htrans;
  logic                 hwrite;
  logic [2:0]           hsize;
  logic [DataWidth-1:0] hwdata;
  logic                 hready;
  logic                 hreadyOut;
  logic                 hresp;
  logic [DataWidth-1:0] hrdata;

  logic                 memValid;
  logic [AddrWidth-1:0] memAddr;
  logic [DataWidth-1:0] memWData;
  logic                 memWrite;
  logic [2:0]           memSize;
  logic [1:0]           memResp;
  logic [DataWidth-1:0] memRData;

  modport slave (
    input  hsel, haddr, htrans, hwrite, hsize, hwdata, hready,
    input  memResp, memRData,
    output hreadyOut, hresp, hrdata,
    output memValid, memAddr, memWData, memWrite, memSize
  );

  modport master (
    output hsel, haddr, htrans, hwrite, hsize, hwdata, hready,
    output memResp, memRData,
    input  hreadyOut, hresp, hrdata,
    input  memValid, memAddr, memWData, memWrite, memSize
  );
endinterface

// File: rtl/ahb_mem_sub.sv
// AHB-Lite subordinate front-end: turns accepted AHB transfers into memory-bus requests, stretches
// the data phase on memory WAIT, aborts on wait timeout and maps errors onto the two-cycle ERROR sequence.
module ahb_mem_sub #(
  parameter int DataWidth = 32,
  parameter int AddrWidth = 32,
  parameter int MaxWait   = 16
) (
  input  logic         clk,
  input  logic         nReset,
  ahb_mem_sub_if.slave bus
);

  localparam int MaxSize = $clog2(DataWidth / 8);
  localparam int CntW    = (MaxWait > 0) ? $clog2(MaxWait + 1) : 1;

  localparam logic [CntW-1:0] CntMax   = '1;
  localparam logic [CntW-1:0] LastWait = (MaxWait > 0) ? CntW'(MaxWait - 1) : '0;

  localparam logic [1:0] RespOkay = 2'b00;
  localparam logic [1:0] RespWait = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCESS,
    S_ERR1,
    S_ERR2
  } state_t;

  state_t               r_state;
  state_t               w_state_next;
  logic [AddrWidth-1:0] r_addr;
  logic                 r_write;
  logic [2:0]           r_size;
  logic [CntW-1:0]      r_wait_cnt;
  logic [CntW-1:0]      w_wait_cnt_next;

  logic                 w_accept;
  logic                 w_take;
  logic                 w_oversize;
  logic                 w_misalign;
  logic                 w_legal;
  logic [AddrWidth-1:0] w_align_mask;
  logic                 w_mem_done;
  logic                 w_mem_wait;
  logic                 w_timeout;

  // Address-phase qualification and legality of the offered transfer.
  assign w_accept     = bus.hsel & bus.hready & bus.htrans[1];
  assign w_oversize   = (bus.hsize > 3'(MaxSize));
  assign w_align_mask = (AddrWidth'(1) << bus.hsize) - AddrWidth'(1);
  assign w_misalign   = |(bus.haddr & w_align_mask);
  assign w_legal      = ~w_oversize & ~w_misalign;

  assign w_mem_done = (bus.memResp == RespOkay);
  assign w_mem_wait = (bus.memResp == RespWait);
  assign w_timeout  = (MaxWait != 0) && (r_wait_cnt == LastWait);

  // A new address phase is only consumed where the previous data phase ends without a stall.
  assign w_take = w_accept & ((r_state == S_IDLE) |
                              (r_state == S_ERR2) |
                              ((r_state == S_ACCESS) & w_mem_done));

  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      r_state    <= S_IDLE;
      r_wait_cnt <= '0;
      r_addr     <= '0;
      r_write    <= 1'b0;
      r_size     <= 3'd0;
    end else begin
      r_state    <= w_state_next;
      r_wait_cnt <= w_wait_cnt_next;
      if (w_take) begin
        r_addr  <= bus.haddr;
        r_write <= bus.hwrite;
        r_size  <= bus.hsize;
      end
    end
  end

  always_comb begin
    w_state_next    = r_state;
    w_wait_cnt_next = r_wait_cnt;

    bus.hreadyOut = 1'b1;
    bus.hresp     = 1'b0;
    bus.hrdata    = '0;
    bus.memValid  = 1'b0;
    bus.memAddr   = '0;
    bus.memWData  = '0;
    bus.memWrite  = 1'b0;
    bus.memSize   = 3'd0;

    case (r_state)
      S_IDLE: begin
        if (w_take) begin
          w_state_next = w_legal ? S_ACCESS : S_ERR1;
        end else begin
          w_state_next = S_IDLE;
        end
      end

      S_ACCESS: begin
        bus.memValid = 1'b1;
        bus.memAddr  = r_addr;
        bus.memWrite = r_write;
        bus.memSize  = r_size;
        bus.memWData = bus.hwdata;
        if (w_mem_done) begin
          bus.hrdata = bus.memRData;
          if (w_take) begin
            w_state_next = w_legal ? S_ACCESS : S_ERR1;
          end else begin
            w_state_next = S_IDLE;
          end
        end else if (w_mem_wait) begin
          bus.hreadyOut = 1'b0;
          if (w_timeout) begin
            w_state_next = S_ERR1;
          end
          if (r_wait_cnt != CntMax) begin
            w_wait_cnt_next = r_wait_cnt + CntW'(1);
          end
        end else begin
          // Memory ERROR (or reserved code) already is the first ERROR cycle.
          bus.hreadyOut = 1'b0;
          bus.hresp     = 1'b1;
          w_state_next  = S_ERR2;
        end
      end

      S_ERR1: begin
        bus.hreadyOut = 1'b0;
        bus.hresp     = 1'b1;
        w_state_next  = S_ERR2;
      end

      S_ERR2: begin
        bus.hresp = 1'b1;
        if (w_take) begin
          w_state_next = w_legal ? S_ACCESS : S_ERR1;
        end else begin
          w_state_next = S_IDLE;
        end
      end

      default: begin
        w_state_next = S_IDLE;
      end
    endcase

    if (w_take) begin
      w_wait_cnt_next = '0;
    end
  end

endmodule

// File: tb/tb_ahb_mem_sub.sv
// Bench for ahb_mem_sub: directed scenarios then random transfers, each transfer expanded into its
// expected per-cycle data-phase trace from the protocol rules and compared cycle by cycle.
module tb_ahb_mem_sub;
  localparam int DW = 32;
  localparam int AW = 32;
  localparam int MW = 4;

  localparam int K_OK  = 0;
  localparam int K_ERR = 1;
  localparam int K_TMO = 2;

  logic clk    = 1'b0;
  logic nReset = 1'b1;

  always #5 clk = ~clk;

  ahb_mem_sub_if #(.DataWidth(DW), .AddrWidth(AW)) bus ();
  assign bus.hready = bus.hreadyOut;

  ahb_mem_sub #(.DataWidth(DW), .AddrWidth(AW), .MaxWait(MW)) dut (
    .clk   (clk),
    .nReset(nReset),
    .bus   (bus)
  );

  typedef struct {
    logic [31:0] addr;
    logic [2:0]  size;
    logic        wr;
    logic        seq;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          waits;
    int          kind;
  } xfer_t;

  typedef struct {
    logic       rdy;
    logic       rsp;
    logic       mval;
    logic [1:0] mresp;
  } phase_t;

  int     total = 0;
  int     bad   = 0;
  xfer_t  pending[$];
  phase_t ph[$];
  xfer_t  cur;
  bit     b2b;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  function automatic bit is_legal(input logic [31:0] a, input logic [2:0] s);
    int bytes;
    if (s > 3'd2) return 1'b0;
    bytes = 1 << s;
    return (a % bytes) == 0;
  endfunction

  function automatic xfer_t mk(input logic [31:0] a, input logic [2:0] s, input logic w,
                               input int kind, input int waits,
                               input logic [31:0] wd, input logic [31:0] rd);
    xfer_t x;
    x.addr  = a;
    x.size  = s;
    x.wr    = w;
    x.seq   = 1'($urandom);
    x.wdata = wd;
    x.rdata = rd;
    x.waits = waits;
    x.kind  = kind;
    return x;
  endfunction

  // Expected data-phase trace of one transfer: (hreadyOut, hresp, memValid) per cycle plus memResp to drive.
  function automatic void build(input xfer_t x);
    int nw;
    ph.delete();
    if (!is_legal(x.addr, x.size)) begin
      ph.push_back('{1'b0, 1'b1, 1'b0, 2'($urandom)});
      ph.push_back('{1'b1, 1'b1, 1'b0, 2'($urandom)});
    end else begin
      nw = (x.kind == K_TMO) ? MW : x.waits;
      for (int i = 0; i < nw; i++) ph.push_back('{1'b0, 1'b0, 1'b1, 2'b10});
      case (x.kind)
        K_OK:  ph.push_back('{1'b1, 1'b0, 1'b1, 2'b00});
        K_ERR: begin
          ph.push_back('{1'b0, 1'b1, 1'b1, ($urandom_range(0, 1) != 0) ? 2'b01 : 2'b11});
          ph.push_back('{1'b1, 1'b1, 1'b0, 2'($urandom)});
        end
        default: begin
          ph.push_back('{1'b0, 1'b1, 1'b0, 2'($urandom)});
          ph.push_back('{1'b1, 1'b1, 1'b0, 2'($urandom)});
        end
      endcase
    end
  endfunction

  // One clock cycle: called and returning #1 after a rising edge.
  task automatic run_cycle();
    phase_t      p;
    bit          in_dp;
    bit          issue;
    xfer_t       nx;
    logic [31:0] rd;
    in_dp = (ph.size() > 0);
    if (in_dp) p = ph.pop_front();
    else       p = '{1'b1, 1'b0, 1'b0, 2'($urandom)};
    issue = (ph.size() == 0) && (pending.size() > 0) && (b2b || ($urandom_range(0, 2) != 0));
    rd = in_dp ? cur.rdata : $urandom;
    bus.memResp  = p.mresp;
    bus.memRData = rd;
    bus.hwdata   = in_dp ? cur.wdata : $urandom;
    if (issue) begin
      nx         = pending.pop_front();
      bus.hsel   = 1'b1;
      bus.htrans = nx.seq ? 2'b11 : 2'b10;
      bus.haddr  = nx.addr;
      bus.hwrite = nx.wr;
      bus.hsize  = nx.size;
    end else begin
      bus.haddr  = $urandom;
      bus.hwrite = 1'($urandom);
      bus.hsize  = 3'($urandom);
      if (!p.rdy) begin
        bus.hsel   = 1'($urandom);
        bus.htrans = 2'($urandom);
      end else if ($urandom_range(0, 1) != 0) begin
        bus.hsel   = 1'b0;
        bus.htrans = 2'($urandom);
      end else begin
        bus.hsel   = 1'b1;
        bus.htrans = {1'b0, 1'($urandom)};
      end
    end
    @(negedge clk);
    check("hreadyOut", 32'(bus.hreadyOut), 32'(p.rdy));
    check("hresp", 32'(bus.hresp), 32'(p.rsp));
    check("memValid", 32'(bus.memValid), 32'(p.mval));
    check("hrdata", bus.hrdata, (p.rdy && p.mval) ? rd : 32'h0);
    if (p.mval) begin
      check("memAddr", bus.memAddr, cur.addr);
      check("memWrite", 32'(bus.memWrite), 32'(cur.wr));
      check("memSize", 32'(bus.memSize), 32'(cur.size));
      check("memWData", bus.memWData, cur.wdata);
    end else begin
      check("memWData_idle", bus.memWData, 32'h0);
    end
    @(posedge clk);
    #1;
    if (issue) begin
      cur = nx;
      build(nx);
    end
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while ((pending.size() > 0 || ph.size() > 0) && n < budget) begin
      run_cycle();
      n++;
    end
    total++;
    assert (pending.size() == 0 && ph.size() == 0) else begin
      bad++;
      $error("FAIL drain_budget observed=%0d_left expected=0_left", pending.size() + ph.size());
    end
  endtask

  initial begin
    logic [2:0]  s;
    logic [31:0] a;
    int          k;

    bus.hsel     = 1'b0;
    bus.htrans   = 2'b00;
    bus.haddr    = '0;
    bus.hwrite   = 1'b0;
    bus.hsize    = 3'd0;
    bus.hwdata   = '0;
    bus.memResp  = 2'b00;
    bus.memRData = '0;
    b2b          = 1'b1;
    nReset       = 1'b0;

    // Reset state
    @(posedge clk);
    #1;
    check("rst_hreadyOut", 32'(bus.hreadyOut), 32'd1);
    check("rst_hresp", 32'(bus.hresp), 32'd0);
    check("rst_hrdata", bus.hrdata, 32'h0);
    check("rst_memValid", 32'(bus.memValid), 32'd0);
    check("rst_memAddr", bus.memAddr, 32'h0);
    check("rst_memWrite", 32'(bus.memWrite), 32'd0);
    check("rst_memSize", 32'(bus.memSize), 32'd0);
    check("rst_memWData", bus.memWData, 32'h0);
    @(posedge clk);
    #1;
    nReset = 1'b1;
    @(posedge clk);
    #1;

    // Zero-wait read
    pending.push_back(mk(32'h10, 3'd2, 1'b0, K_OK, 0, 32'h0, 32'hDEADBEEF));
    drain(20);
    // Write with three wait states
    pending.push_back(mk(32'h20, 3'd2, 1'b1, K_OK, 3, 32'hA5A5A5A5, 32'h0));
    drain(20);
    // Misaligned word and oversize transfer
    pending.push_back(mk(32'h3, 3'd2, 1'b0, K_OK, 0, 32'h0, 32'h1));
    pending.push_back(mk(32'h8, 3'd3, 1'b1, K_OK, 0, 32'h2, 32'h3));
    drain(20);
    // Wait timeout
    pending.push_back(mk(32'h30, 3'd2, 1'b0, K_TMO, 0, 32'h4, 32'h5));
    drain(20);
    // Back-to-back OKAY reads
    pending.push_back(mk(32'h0, 3'd2, 1'b0, K_OK, 0, 32'h0, 32'h11111111));
    pending.push_back(mk(32'h4, 3'd2, 1'b0, K_OK, 0, 32'h0, 32'h22222222));
    pending.push_back(mk(32'h8, 3'd2, 1'b0, K_OK, 0, 32'h0, 32'h33333333));
    drain(20);
    // Memory ERROR on the middle one; third accepted during ERR2
    pending.push_back(mk(32'h0, 3'd2, 1'b0, K_OK, 0, 32'h0, 32'h44444444));
    pending.push_back(mk(32'h4, 3'd2, 1'b0, K_ERR, 0, 32'h0, 32'h55555555));
    pending.push_back(mk(32'h8, 3'd2, 1'b0, K_OK, 0, 32'h0, 32'h66666666));
    drain(20);

    // Reset asserted mid-ACCESS while memory is stalling
    pending.push_back(mk(32'h40, 3'd2, 1'b1, K_OK, 3, 32'h12345678, 32'h0));
    run_cycle();
    run_cycle();
    bus.memResp = 2'b10;
    bus.hsel    = 1'b0;
    bus.htrans  = 2'b00;
    #1;
    check("pre_rst_memValid", 32'(bus.memValid), 32'd1);
    nReset = 1'b0;
    #1;
    check("in_rst_memValid", 32'(bus.memValid), 32'd0);
    check("in_rst_memWData", bus.memWData, 32'h0);
    check("in_rst_hreadyOut", 32'(bus.hreadyOut), 32'd1);
    check("in_rst_hresp", 32'(bus.hresp), 32'd0);
    ph.delete();
    @(posedge clk);
    @(posedge clk);
    #1;
    nReset = 1'b1;
    @(negedge clk);
    check("post_rst_hreadyOut", 32'(bus.hreadyOut), 32'd1);
    check("post_rst_hresp", 32'(bus.hresp), 32'd0);
    check("post_rst_memValid", 32'(bus.memValid), 32'd0);
    check("post_rst_memAddr", bus.memAddr, 32'h0);
    @(posedge clk);
    #1;

    // Random traffic with random gaps
    b2b = 1'b0;
    for (int i = 0; i < 150; i++) begin
      s = 3'($urandom_range(0, 3));
      a = $urandom & 32'h0000_FFFF;
      if ($urandom_range(0, 2) != 0) a = a & ~((32'd1 << s) - 32'd1);
      k = $urandom_range(0, 5);
      pending.push_back(mk(a, s, 1'($urandom), (k < 4) ? K_OK : ((k == 4) ? K_ERR : K_TMO),
                           $urandom_range(0, MW - 1), $urandom, $urandom));
    end
    drain(5000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
